ethernet_icmp_request_receiver: RTL and testbench

- Byte-serial receiver for ICMP echo requests; the inbound counterpart of the ICMP reply transmitter.
- Deserializes a contiguous i_word/i_valid frame into a 42-byte header vector and a payload vector of up to 63 bytes.
- Validates EtherType, IP protocol and ICMP type, then presents the frame to the reply-generation logic with a one-cycle ready pulse.
- Vector layout matches the transmitter's head/payload/size inputs so a reply builder can sit between the two blocks.

---
 rtl/ethernet_icmp_request_receiver.sv | 134 +++++++++++++
 tb/tb_ethernet_icmp_request_receiver.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ethernet_icmp_request_receiver.sv
// ethernet_icmp_request_receiver: deserializes an ICMP echo request frame into header/payload vectors.
// Define ICMP_RX_IP_CSUM_CHECK_EN to also reject frames whose IPv4 header checksum is wrong.
module ethernet_icmp_request_receiver #(
    parameter int              HEAD_BYTES         = 42,
    parameter int              PAYLOAD_MAX        = 63,
    parameter logic [15:0]     ETHERTYPE_IPV4     = 16'h0800,
    parameter logic [7:0]      IP_PROTO_ICMP      = 8'h01,
    parameter logic [7:0]      ICMP_TYPE_ECHO_REQ = 8'h08
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [7:0]   i_word,
    input  logic         i_valid,
    output logic [399:0] o_icmp_request_head,
    output logic [503:0] o_icmp_request_payload,
    output logic [5:0]   o_icmp_request_payload_size,
    output logic         o_icmp_request_ready,
    output logic         o_drop
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HEAD    = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_DROP    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [5:0] HEAD_LAST = 6'(HEAD_BYTES - 1);
    localparam logic [5:0] PAY_MAX   = 6'(PAYLOAD_MAX);

    logic [2:0]   r_state;
    logic [5:0]   r_head_cnt;
    logic [5:0]   r_pay_cnt;
    logic [399:0] r_head_cap;
    logic [503:0] r_pay_cap;
    logic         r_bad;
    logic         r_rej;
    logic         w_start;
    logic         w_byte_bad;
    logic         w_csum_ok;
    logic         w_accept;

    assign w_start = i_valid && (r_state == S_IDLE || r_state == S_DONE);
    // Field checks run as the bytes stream past, so the vectors are never re-read.
    assign w_byte_bad = (r_head_cnt == 6'd12 && i_word != ETHERTYPE_IPV4[15:8]) ||
                        (r_head_cnt == 6'd13 && i_word != ETHERTYPE_IPV4[7:0]) ||
                        (r_head_cnt == 6'd23 && i_word != IP_PROTO_ICMP) ||
                        (r_head_cnt == 6'd34 && i_word != ICMP_TYPE_ECHO_REQ);
    assign w_accept = !r_bad && !r_rej && w_csum_ok;

`ifdef ICMP_RX_IP_CSUM_CHECK_EN
    logic [16:0] r_csum;
    logic [16:0] w_csum_add;
    logic [16:0] w_csum_sum;
    logic [15:0] w_csum_fold;
    assign w_csum_add  = r_head_cnt[0] ? {9'd0, i_word} : {1'b0, i_word, 8'd0};
    assign w_csum_sum  = {1'b0, r_csum[15:0]} + {16'd0, r_csum[16]} + w_csum_add;
    assign w_csum_fold = r_csum[15:0] + {15'd0, r_csum[16]};
    assign w_csum_ok   = w_csum_fold == 16'hFFFF;
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_csum <= '0;
        else if (w_start)
            r_csum <= '0;
        else if (r_state == S_HEAD && i_valid && r_head_cnt >= 6'd14 && r_head_cnt <= 6'd33)
            r_csum <= w_csum_sum;
    end
`else
    assign w_csum_ok = 1'b1;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state                     <= S_IDLE;
            r_head_cnt                  <= '0;
            r_pay_cnt                   <= '0;
            r_head_cap                  <= '0;
            r_pay_cap                   <= '0;
            r_bad                       <= 1'b0;
            r_rej                       <= 1'b0;
            o_icmp_request_head         <= '0;
            o_icmp_request_payload      <= '0;
            o_icmp_request_payload_size <= '0;
            o_icmp_request_ready        <= 1'b0;
            o_drop                      <= 1'b0;
        end else begin
            o_icmp_request_ready <= 1'b0;
            o_drop               <= 1'b0;
            if (r_state == S_DONE) begin
                o_icmp_request_ready <= w_accept;
                o_drop               <= !w_accept;
                if (w_accept) begin
                    o_icmp_request_head         <= r_head_cap;
                    o_icmp_request_payload      <= r_pay_cap;
                    o_icmp_request_payload_size <= r_pay_cnt;
                end
            end
            if (w_start) begin
                r_state    <= S_HEAD;
                r_head_cnt <= 6'd1;
                r_pay_cnt  <= '0;
                r_head_cap <= {i_word, 392'd0};
                r_pay_cap  <= '0;
                r_bad      <= 1'b0;
                r_rej      <= 1'b0;
            end else begin
                case (r_state)
                    S_HEAD: begin
                        if (i_valid) begin
                            r_head_cap[399 - 8*int'(r_head_cnt) -: 8] <= i_word;
                            r_head_cnt <= r_head_cnt + 6'd1;
                            r_bad      <= r_bad | w_byte_bad;
                            if (r_head_cnt == HEAD_LAST)
                                r_state <= S_PAYLOAD;
                        end else begin
                            r_rej   <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                    S_PAYLOAD: begin
                        if (!i_valid)
                            r_state <= S_DONE;
                        else if (r_pay_cnt == PAY_MAX) begin
                            r_rej   <= 1'b1;
                            r_state <= S_DROP;
                        end else begin
                            r_pay_cap[503 - 8*int'(r_pay_cnt) -: 8] <= i_word;
                            r_pay_cnt <= r_pay_cnt + 6'd1;
                        end
                    end
                    S_DROP:  r_state <= i_valid ? S_DROP : S_DONE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ethernet_icmp_request_receiver.sv
// tb_ethernet_icmp_request_receiver: random frames scored against a frame-level model of the receiver.
module tb_ethernet_icmp_request_receiver;
    logic         clk = 0;
    logic         i_reset = 1;
    logic [7:0]   i_word = 0;
    logic         i_valid = 0;
    logic [399:0] o_head;
    logic [503:0] o_pay;
    logic [5:0]   o_size;
    logic         o_ready;
    logic         o_drop;

    ethernet_icmp_request_receiver dut (
        .i_clk(clk), .i_reset(i_reset), .i_word(i_word), .i_valid(i_valid),
        .o_icmp_request_head(o_head), .o_icmp_request_payload(o_pay),
        .o_icmp_request_payload_size(o_size), .o_icmp_request_ready(o_ready), .o_drop(o_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        bit           acc;
        logic [399:0] head;
        logic [503:0] pay;
        logic [5:0]   size;
    } exp_t;

    int           n_chk = 0;
    int           n_err = 0;
    int           cyc = 0;
    logic [7:0]   frm[$];
    exp_t         q[$];
    exp_t         e_mon;
    logic [399:0] m_head = '0;
    logic [503:0] m_pay = '0;
    logic [5:0]   m_size = '0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Frame-level expectation: length limits, field values and (optionally) IPv4 checksum.
    function automatic exp_t model(input int c);
        exp_t e;
        int   len = frm.size();
        int   s = 0;
        e.cyc = c; e.head = '0; e.pay = '0; e.size = '0;
        e.acc = len >= 42 && len - 42 <= 63;
        if (e.acc) begin
            e.acc = frm[12] == 8'h08 && frm[13] == 8'h00 && frm[23] == 8'h01 && frm[34] == 8'h08;
            for (int i = 14; i < 34; i += 2) s += {frm[i], frm[i+1]};
            while (s > 16'hFFFF) s = (s & 16'hFFFF) + (s >> 16);
`ifdef ICMP_RX_IP_CSUM_CHECK_EN
            e.acc = e.acc && s == 16'hFFFF;
`endif
            for (int i = 0; i < 42; i++) e.head[399 - 8*i -: 8] = frm[i];
            for (int i = 42; i < len; i++) e.pay[503 - 8*(i-42) -: 8] = frm[i];
            e.size = 6'(len - 42);
        end
        return e;
    endfunction

    task automatic mk_frame(input int plen);
        int s = 0;
        frm.delete();
        for (int i = 0; i < 42 + plen; i++) frm.push_back(8'($urandom));
        frm[12] = 8'h08; frm[13] = 8'h00; frm[14] = 8'h45; frm[23] = 8'h01; frm[34] = 8'h08;
        frm[24] = 8'h00; frm[25] = 8'h00;
        for (int i = 14; i < 34; i += 2) s += {frm[i], frm[i+1]};
        while (s > 16'hFFFF) s = (s & 16'hFFFF) + (s >> 16);
        s = ~s & 16'hFFFF;
        frm[24] = 8'(s >> 8); frm[25] = 8'(s);
    endtask

    task automatic send(input int gap);
        for (int i = 0; i < frm.size(); i++) begin
            @(posedge clk); #1;
            i_valid = 1; i_word = frm[i];
        end
        @(posedge clk); #1;
        i_valid = 0; i_word = 0;
        q.push_back(model(cyc + 2));
        repeat (gap - 1) @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (!i_reset) begin
            check("pulse_excl", {1'b0, o_ready & o_drop}, 0);
            if (o_ready | o_drop) begin
                if (q.size() == 0) check("spurious_pulse", {o_ready, o_drop}, 0);
                else begin
                    e_mon = q.pop_front();
                    check("latency", cyc, e_mon.cyc);
                    check("ready", o_ready, e_mon.acc);
                    check("drop", o_drop, !e_mon.acc);
                    if (e_mon.acc) begin
                        m_head = e_mon.head; m_pay = e_mon.pay; m_size = e_mon.size;
                    end
                end
            end
            check("head", o_head, m_head);
            check("payload", o_pay, m_pay);
            check("size", o_size, m_size);
        end
    end

    initial begin
        #1;
        check("rst_head", o_head, 0);
        check("rst_payload", o_pay, 0);
        check("rst_size", o_size, 0);
        check("rst_pulses", {o_ready, o_drop}, 0);
        repeat (2) @(posedge clk);
        #1 i_reset = 0;
        mk_frame(4);
        frm[42] = 8'hDE; frm[43] = 8'hAD; frm[44] = 8'hBE; frm[45] = 8'hEF;
        send(4);
        check("deadbeef", o_pay[503:472], 32'hDEADBEEF);
        check("deadbeef_rest", o_pay[471:0], 0);
        check("deadbeef_size", o_size, 4);
        check("head_byte0", o_head[399:392], frm[0]);
        mk_frame(0);
        send(4);
        check("hdr_only_size", o_size, 0);
        check("hdr_only_pay", o_pay, 0);
        mk_frame(5); frm[34] = 8'h00; send(3);
        mk_frame(5); frm[13] = 8'h06; send(3);
        mk_frame(0); while (frm.size() > 30) void'(frm.pop_back()); send(3);
        mk_frame(64); send(1);
        mk_frame(10); send(1);
        mk_frame(7); send(1);
        mk_frame(63); send(3);
        mk_frame(8);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            i_valid = 1; i_word = frm[i];
        end
        @(posedge clk); #2;
        i_reset = 1; i_valid = 0;
        m_head = '0; m_pay = '0; m_size = '0;
        #1;
        check("midrst_head", o_head, 0);
        check("midrst_payload", o_pay, 0);
        check("midrst_size", o_size, 0);
        check("midrst_pulses", {o_ready, o_drop}, 0);
        repeat (2) @(posedge clk);
        #1 i_reset = 0;
        repeat (3) @(posedge clk);
        mk_frame(12); send(2);
        mk_frame(6); frm[24] = frm[24] ^ 8'h5A; send(2);
        for (int n = 0; n < 30; n++) begin
            int kind = $urandom_range(0, 4);
            int gap = $urandom_range(1, 3);
            if (kind <= 1) mk_frame($urandom_range(0, 63));
            else if (kind == 2) begin
                int idx = $urandom_range(0, 3);
                mk_frame($urandom_range(0, 20));
                idx = idx == 0 ? 12 : idx == 1 ? 13 : idx == 2 ? 23 : 34;
                frm[idx] = frm[idx] ^ 8'($urandom_range(1, 255));
            end else if (kind == 3) begin
                int len = $urandom_range(1, 41);
                mk_frame(0);
                while (frm.size() > len) void'(frm.pop_back());
            end else mk_frame($urandom_range(64, 70));
            send(gap);
        end
        repeat (6) @(posedge clk);
        #1;
        check("pending_frames", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
